pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline control block that produces the `freeze` and `flush` controls consumed by the ID/EXE pipeline register and the IF stage. It tracks every in-flight destination register in a three-slot scoreboard (EXE, MEM, WB) and stalls ID on read-after-write hazards. It also flushes ID when EXE resolves a taken branch, and freezes the whole pipeline while a multi-cycle data-memory access is in progress.

## Interface
Parameters:
- `MEM_WAIT`, default 4: cycles an access with mem=1 occupies the MEM stage; legal values are 1 to 15.
- `FWD_EN`, default 0: 1 means a forwarding unit exists, so only load-use hazards stall.

Ports (reset rst, asynchronous, active-high; clock clk):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `id_valid`  in  1  ID holds a real instruction
- `id_src1`  in  4  Rn index of ID instruction
- `id_src2`  in  4  Rm/Rd index of ID instruction
- `id_use_src1`  in  1  ID instruction reads src1
- `id_use_src2`  in  1  ID instruction reads src2
- `id_wb_en`  in  1  ID instruction writes the register file
- `id_mem_r_en`  in  1  ID instruction is a load
- `id_mem_w_en`  in  1  ID instruction is a store
- `id_dest`  in  4  ID destination index
- `exe_branch_taken`  in  1  branch in EXE taken this cycle
- `freeze_if`  out  1  hold PC and the IF/ID register
- `freeze_id`  out  1  hold the ID/EXE register; asserted only during a memory stall
- `flush_id`  out  1  clear the ID/EXE register (insert bubble)
- `mem_stall`  out  1  freeze the EXE/MEM and MEM/WB registers
- `busy`  out  1  any scoreboard slot occupied

## Operation
Scoreboard:
- Three slots, E, M and W, with fields {wb, ld, mem, dest}. A slot is occupied when wb=1 or mem=1.
- Advance condition: mem_stall=0. On advance, W<=M, M<=E, E<=issue.
- If mem_stall=1, all slots hold.
- issue = {id_wb_en, id_mem_r_en, id_mem_r_en|id_mem_w_en, id_dest} when id_valid=1, hazard=0 and flush_id=0. Otherwise issue is all-zero, i.e. a bubble.

Hazard, combinational:
- A slot X matches src1 when: X.wb=1, id_use_src1=1 and X.dest==id_src1. The same rule applies to src2.
- FWD_EN=0: hazard = id_valid & (E or M matches src1 or src2).
- FWD_EN=1: hazard = id_valid & E.ld & (E matches src1 or src2).
- The W slot never causes a hazard, because the register file writes before it is read.

Outputs:
- flush_id = exe_branch_taken & ~mem_stall.
- freeze_if = mem_stall | (hazard & ~exe_branch_taken). A branch beats a hazard because the instruction in ID is discarded.
- A hazard bubble is inserted by issuing a bubble into E. freeze_id is not raised, so the ID/EXE register captures a NOP through the bubble path; this clears that register's write enables.
- freeze_id = mem_stall.
- busy = E, M or W occupied.

Memory wait:
- A 4-bit counter `wait_cnt`.
- On an advance that loads M with mem=1 and MEM_WAIT>1, wait_cnt <= MEM_WAIT-1.
- While wait_cnt != 0, mem_stall=1 and wait_cnt decrements each cycle.
- mem_stall = (wait_cnt != 0), driven directly from the register.
- The instruction therefore spends exactly MEM_WAIT cycles in M.
- With MEM_WAIT=1, mem_stall is never asserted.
- Back-to-back memory instructions each incur the full wait.

Branch during stall:
- exe_branch_taken stays asserted because EXE is frozen.
- The flush takes effect in the first cycle after mem_stall falls.

## Timing
- Reset: slots, wait_cnt and busy are 0. All outputs are forced to 0 while rst=1.
- Release of rst is synchronous to the next clk edge.
- flush_id, freeze_if and hazard are combinational from inputs in the same cycle; they are registered by the consuming stage on the next edge.
- Scoreboard latency: a value issued at edge n sits in E after n, in M after n+1 and in W after n+2.
- With FWD_EN=0, a dependent instruction waits 2 cycles when the producer is directly ahead, and 1 cycle when there is one instruction in between.
- With FWD_EN=1, a load-use pair waits exactly 1 cycle.
- Simultaneous exe_branch_taken and hazard: flush wins; freeze_if=0; a bubble is issued.
- Reset mid-stall: wait_cnt and slots clear immediately; mem_stall drops asynchronously.
- Bubble slots carry dest=0 with wb=0, so they never match R0.

## Test plan
- Reset, then no instructions: all outputs 0 and busy=0. Assert rst mid-stall with wait_cnt=2: mem_stall becomes 0 immediately.
- FWD_EN=0, ADD R1 followed by SUB R2,R1,R3 (src1=1, use_src1=1): freeze_if=1 for 2 cycles with bubbles in E; the SUB issues on the 3rd cycle. Repeat with one independent instruction in between: 1 stall cycle.
- FWD_EN=1, LDR R4 followed by ADD R5,R4,R4: exactly 1 stall cycle. ADD R4 followed by ADD R5,R4: 0 stall cycles.
- MEM_WAIT=4, STR enters M: mem_stall=1 and freeze_id=1 for 3 cycles, scoreboard frozen; released on the 4th. Two consecutive LDRs give two separate 3-cycle stalls.
- exe_branch_taken=1 with a hazard pending on ID: flush_id=1, freeze_if=0, E gets a bubble next cycle.
- exe_branch_taken held high through a 3-cycle mem_stall: flush_id=0 during the stall, then 1 in the first cycle after the stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of ID-stage hazard inputs and pipeline freeze/flush controls
// shared by the hazard controller and the pipeline datapath.
interface pipe_hazard_ctrl_if;
    logic       id_valid;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_use_src1;
    logic       id_use_src2;
    logic       id_wb_en;
    logic       id_mem_r_en;
    logic       id_mem_w_en;
    logic [3:0] id_dest;
    logic       exe_branch_taken;
    logic       freeze_if;
    logic       freeze_id;
    logic       flush_id;
    logic       mem_stall;
    logic       busy;

    modport master (
        output id_valid, id_src1, id_src2, id_use_src1, id_use_src2,
               id_wb_en, id_mem_r_en, id_mem_w_en, id_dest, exe_branch_taken,
        input  freeze_if, freeze_id, flush_id, mem_stall, busy
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_use_src1, id_use_src2,
               id_wb_en, id_mem_r_en, id_mem_w_en, id_dest, exe_branch_taken,
        output freeze_if, freeze_id, flush_id, mem_stall, busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: EXE/MEM/WB destination scoreboard, RAW stall
// detection, branch flush and multi-cycle memory freeze.
module pipe_hazard_ctrl #(
    parameter int MEM_WAIT = 4,
    parameter bit FWD_EN   = 1'b0
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave ctrl
);

    typedef struct packed {
        logic       wb;
        logic       ld;
        logic       mem;
        logic [3:0] dest;
    } slot_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    slot_t      slot_e;
    slot_t      slot_m;
    slot_t      slot_w;
    slot_t      issue;
    logic [3:0] wait_cnt;
    logic       mem_stall;
    logic       e_match;
    logic       m_match;
    logic       hazard;
    logic       flush;

    assign mem_stall = (wait_cnt != 4'd0);

    assign e_match = slot_e.wb &&
                     ((ctrl.id_use_src1 && (slot_e.dest == ctrl.id_src1)) ||
                      (ctrl.id_use_src2 && (slot_e.dest == ctrl.id_src2)));
    assign m_match = slot_m.wb &&
                     ((ctrl.id_use_src1 && (slot_m.dest == ctrl.id_src1)) ||
                      (ctrl.id_use_src2 && (slot_m.dest == ctrl.id_src2)));

    // With forwarding only a load still in EXE can't supply its result in time.
    assign hazard = ctrl.id_valid &&
                    (FWD_EN ? (slot_e.ld && e_match) : (e_match || m_match));

    assign flush = ctrl.exe_branch_taken && !mem_stall;

    assign ctrl.flush_id  = !rst && flush;
    assign ctrl.freeze_if = !rst && (mem_stall || (hazard && !ctrl.exe_branch_taken));
    assign ctrl.freeze_id = mem_stall;
    assign ctrl.mem_stall = mem_stall;
    assign ctrl.busy      = |{slot_e, slot_m, slot_w};

    // Instructions that neither write back nor touch memory are stored as
    // all-zero bubbles, so a slot is occupied exactly when it is non-zero.
    always_comb begin
        issue = '0;
        if (ctrl.id_valid && !hazard && !flush &&
            (ctrl.id_wb_en || ctrl.id_mem_r_en || ctrl.id_mem_w_en)) begin
            issue.wb   = ctrl.id_wb_en;
            issue.ld   = ctrl.id_mem_r_en;
            issue.mem  = ctrl.id_mem_r_en || ctrl.id_mem_w_en;
            issue.dest = ctrl.id_dest;
        end
    end

    // A memory op entering M loads the counter; WAIT_LOAD is 0 when
    // MEM_WAIT is 1, so no stall is produced in that case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_e   <= '0;
            slot_m   <= '0;
            slot_w   <= '0;
            wait_cnt <= 4'd0;
        end else if (!mem_stall) begin
            slot_w <= slot_m;
            slot_m <= slot_e;
            slot_e <= issue;
            if (slot_e.mem) begin
                wait_cnt <= WAIT_LOAD;
            end
        end else begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two controllers (no forwarding / forwarding) share random
// and directed ID stimulus and are compared against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MW0 = 4;
    localparam int MW1 = 2;

    typedef struct packed {
        logic       valid;
        logic [3:0] src1;
        logic [3:0] src2;
        logic       use1;
        logic       use2;
        logic       wb;
        logic       rd;
        logic       wr;
        logic [3:0] dest;
        logic       br;
    } stim_t;

    typedef struct packed {
        logic freeze_if;
        logic freeze_id;
        logic flush_id;
        logic mem_stall;
        logic busy;
    } outs_t;

    typedef struct packed {
        logic       wb;
        logic       ld;
        logic       mem;
        logic [3:0] dest;
    } mslot_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    outs_t  exp_q0[$];
    outs_t  exp_q1[$];
    mslot_t ms[2][3];
    int     mage[2];
    outs_t  mon_a0, mon_a1, mon_e0, mon_e1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus0 ();
    pipe_hazard_ctrl_if bus1 ();

    pipe_hazard_ctrl #(.MEM_WAIT(MW0), .FWD_EN(1'b0)) dut0 (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus0)
    );

    pipe_hazard_ctrl #(.MEM_WAIT(MW1), .FWD_EN(1'b1)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus1)
    );

    function automatic stim_t mkAlu(input int dst, input int s1, input int s2,
                                    input logic u2);
        stim_t s = '0;
        s.valid = 1'b1; s.wb = 1'b1; s.dest = 4'(dst);
        s.src1 = 4'(s1); s.use1 = 1'b1; s.src2 = 4'(s2); s.use2 = u2;
        return s;
    endfunction

    function automatic stim_t mkLdr(input int dst, input int base);
        stim_t s = '0;
        s.valid = 1'b1; s.wb = 1'b1; s.rd = 1'b1; s.dest = 4'(dst);
        s.src1 = 4'(base); s.use1 = 1'b1;
        return s;
    endfunction

    function automatic stim_t mkStr(input int src, input int base);
        stim_t s = '0;
        s.valid = 1'b1; s.wr = 1'b1;
        s.src1 = 4'(base); s.use1 = 1'b1; s.src2 = 4'(src); s.use2 = 1'b1;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s = '0;
        s.valid = ($urandom_range(0, 9) < 8);
        s.src1  = 4'($urandom_range(0, 3));
        s.src2  = 4'($urandom_range(0, 3));
        s.use1  = 1'($urandom_range(0, 1));
        s.use2  = 1'($urandom_range(0, 1));
        s.rd    = ($urandom_range(0, 4) == 0);
        s.wr    = !s.rd && ($urandom_range(0, 7) == 0);
        s.wb    = s.rd || (!s.wr && ($urandom_range(0, 3) != 0));
        s.dest  = 4'($urandom_range(0, 3));
        s.br    = ($urandom_range(0, 9) == 0);
        return s;
    endfunction

    function automatic logic reads(input mslot_t sl, input stim_t s);
        return sl.wb && ((s.use1 && sl.dest == s.src1) || (s.use2 && sl.dest == s.src2));
    endfunction

    task automatic drive(input stim_t s);
        bus0.id_valid = s.valid;  bus1.id_valid = s.valid;
        bus0.id_src1 = s.src1;    bus1.id_src1 = s.src1;
        bus0.id_src2 = s.src2;    bus1.id_src2 = s.src2;
        bus0.id_use_src1 = s.use1; bus1.id_use_src1 = s.use1;
        bus0.id_use_src2 = s.use2; bus1.id_use_src2 = s.use2;
        bus0.id_wb_en = s.wb;     bus1.id_wb_en = s.wb;
        bus0.id_mem_r_en = s.rd;  bus1.id_mem_r_en = s.rd;
        bus0.id_mem_w_en = s.wr;  bus1.id_mem_w_en = s.wr;
        bus0.id_dest = s.dest;    bus1.id_dest = s.dest;
        bus0.exe_branch_taken = s.br; bus1.exe_branch_taken = s.br;
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int st = 0; st < 3; st++) ms[k][st] = '0;
            mage[k] = 0;
        end
    endtask

    // Model keeps the instructions in E/M/W plus the number of cycles the M
    // occupant has already waited; outputs follow from those facts directly.
    task automatic modelStep(input int k, input stim_t s, output outs_t o);
        int   mw;
        logic fw, stall, haz;
        mw    = (k == 0) ? MW0 : MW1;
        fw    = (k == 1);
        stall = ms[k][1].mem && (mage[k] < mw - 1);
        haz   = 1'b0;
        for (int st = 0; st < 2; st++)
            if (s.valid && reads(ms[k][st], s) && (!fw || (st == 0 && ms[k][0].ld)))
                haz = 1'b1;
        o.flush_id  = s.br && !stall;
        o.freeze_if = stall || (haz && !s.br);
        o.freeze_id = stall;
        o.mem_stall = stall;
        o.busy      = 1'b0;
        for (int st = 0; st < 3; st++)
            if (ms[k][st].wb || ms[k][st].mem) o.busy = 1'b1;
        if (!stall) begin
            ms[k][2] = ms[k][1];
            ms[k][1] = ms[k][0];
            ms[k][0] = (s.valid && !haz && !o.flush_id) ? {s.wb, s.rd, s.rd | s.wr, s.dest} : '0;
            mage[k]  = 0;
        end else begin
            mage[k]++;
        end
    endtask

    task automatic checkOutput(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic checkPair(input string tag, input outs_t act, input outs_t exp);
        checkOutput({tag, ".freeze_if"}, act.freeze_if, exp.freeze_if);
        checkOutput({tag, ".freeze_id"}, act.freeze_id, exp.freeze_id);
        checkOutput({tag, ".flush_id"},  act.flush_id,  exp.flush_id);
        checkOutput({tag, ".mem_stall"}, act.mem_stall, exp.mem_stall);
        checkOutput({tag, ".busy"},      act.busy,      exp.busy);
    endtask

    function automatic outs_t grab0();
        return {bus0.freeze_if, bus0.freeze_id, bus0.flush_id, bus0.mem_stall, bus0.busy};
    endfunction

    function automatic outs_t grab1();
        return {bus1.freeze_if, bus1.freeze_id, bus1.flush_id, bus1.mem_stall, bus1.busy};
    endfunction

    task automatic applyStimulus(input stim_t s);
        outs_t o0, o1;
        @(posedge clk);
        #1;
        drive(s);
        modelStep(0, s, o0);
        modelStep(1, s, o1);
        exp_q0.push_back(o0);
        exp_q1.push_back(o1);
    endtask

    task automatic doReset(input string tag);
        @(negedge clk);
        #1;
        rst = 1'b1;
        drive('0);
        #1;
        checkPair({tag, ".dut0"}, grab0(), '0);
        checkPair({tag, ".dut1"}, grab1(), '0);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares whatever the DUTs present against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && exp_q0.size() > 0) begin
            mon_e0 = exp_q0.pop_front();
            mon_e1 = exp_q1.pop_front();
            mon_a0 = grab0();
            mon_a1 = grab1();
            checkPair("dut0", mon_a0, mon_e0);
            checkPair("dut1", mon_a1, mon_e1);
        end
    end

    initial begin
        stim_t br_s;
        rst = 1'b1;
        drive('0);
        modelReset();
        #12;
        checkPair("rst_init.dut0", grab0(), '0);
        checkPair("rst_init.dut1", grab1(), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus('0);

        // RAW with producer directly ahead, then with one instruction between.
        applyStimulus(mkAlu(1, 5, 6, 1'b1));
        for (int i = 0; i < 3; i++) applyStimulus(mkAlu(2, 1, 3, 1'b1));
        applyStimulus(mkAlu(1, 5, 6, 1'b1));
        applyStimulus(mkAlu(7, 8, 9, 1'b1));
        for (int i = 0; i < 2; i++) applyStimulus(mkAlu(2, 1, 3, 1'b1));
        for (int i = 0; i < 4; i++) applyStimulus('0);

        // Load-use versus ALU-use.
        applyStimulus(mkLdr(4, 0));
        for (int i = 0; i < 3; i++) applyStimulus(mkAlu(5, 4, 4, 1'b1));
        for (int i = 0; i < 8; i++) applyStimulus('0);
        applyStimulus(mkAlu(4, 1, 2, 1'b1));
        applyStimulus(mkAlu(5, 4, 0, 1'b0));
        for (int i = 0; i < 4; i++) applyStimulus('0);

        // Store stall, then two back-to-back loads.
        applyStimulus(mkStr(3, 2));
        for (int i = 0; i < 6; i++) applyStimulus('0);
        applyStimulus(mkLdr(6, 0));
        applyStimulus(mkLdr(7, 0));
        for (int i = 0; i < 10; i++) applyStimulus('0);

        // Branch with a hazard pending on ID.
        applyStimulus(mkAlu(3, 0, 0, 1'b0));
        br_s = mkAlu(2, 3, 3, 1'b1);
        br_s.br = 1'b1;
        applyStimulus(br_s);
        for (int i = 0; i < 3; i++) applyStimulus('0);

        // Branch held through a memory stall.
        applyStimulus(mkStr(1, 2));
        applyStimulus('0);
        br_s = '0;
        br_s.br = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(br_s);
        for (int i = 0; i < 4; i++) applyStimulus('0);

        // Reset asserted while the counter is mid-way through a wait.
        applyStimulus(mkStr(1, 2));
        for (int i = 0; i < 3; i++) applyStimulus('0);
        doReset("rst_mid");

        for (int i = 0; i < 600; i++) applyStimulus(randStim());
        doReset("rst_late");
        for (int i = 0; i < 200; i++) applyStimulus(randStim());

        repeat (3) @(negedge clk);
        checkOutput("queue_drain", (exp_q0.size() == 0) && (exp_q1.size() == 0), 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
